piezo_tone_seq: RTL and testbench

Parametrised successor to the free-running piezo driver. It accepts one tone request at a time over a valid/ready handshake. Each request carries a half-period divisor, a tone duration and a trailing silence, all timed in milliseconds, so callers such as the Morse keyer no longer time tones themselves. The block drives the piezo pin directly and reports busy/done to the sequencing logic.

---
 rtl/piezo_pkg.sv | 28 ++
 rtl/ms_tick_gen.sv | 45 ++++
 rtl/piezo_tone_seq.sv | 215 +++++++++++++++++++++
 tb/tb_piezo_tone_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piezo_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : piezo_pkg
//  Description : Shared types and constants for the piezo tone sequencer and
//                the blocks that feed it (e.g. the Morse keyer).
//  Revision    : 1.0 - initial release
// ============================================================================
package piezo_pkg;

    // Sequencer states: waiting, sounding the tone, trailing silence.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } tone_state_t;

    // Field widths shared with request producers.
    localparam int unsigned c_div_w = 24;
    localparam int unsigned c_dur_w = 16;

    // Clock cycles per millisecond; never below one so the prescaler stays valid.
    function automatic int unsigned ms_cycles(input int unsigned clk_hz);
        return (clk_hz < 32'd1000) ? 32'd1 : (clk_hz / 32'd1000);
    endfunction

endpackage : piezo_pkg
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ms_tick_gen
//  Description : Millisecond prescaler. Emits a one-cycle tick every MS_CYC
//                cycles; a synchronous restart zeroes the count so the next
//                tick lands exactly MS_CYC cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_gen #(
    parameter int unsigned MS_CYC = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned       c_cnt_w = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(MS_CYC - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    // Next count: wrap at the last cycle of a millisecond, or restart.
    always_comb begin
        cnt_d = cnt_q + c_cnt_w'(1);
        if (restart || (cnt_q == c_last)) begin
            cnt_d = '0;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == c_last);

endmodule : ms_tick_gen
`default_nettype wire

// File: rtl/piezo_tone_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : piezo_tone_seq
//  Description : One-request-at-a-time piezo tone sequencer. Each request
//                carries a half-period divisor, a tone length and a trailing
//                silence in milliseconds; the block drives the piezo pin and
//                reports busy/done.
//  Options     : PIEZO_DUTY_EN - adds req_high for programmable high-phase
//                length (clamped to 1..2N-1); otherwise fixed 50% duty.
//  Revision    : 1.0 - initial release
// ============================================================================
module piezo_tone_seq
    import piezo_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIV_W  = c_div_w,
    parameter int unsigned DUR_W  = c_dur_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DIV_W-1:0] req_half_div,
    input  logic [DUR_W-1:0] req_dur_ms,
    input  logic [DUR_W-1:0] req_gap_ms,
`ifdef PIEZO_DUTY_EN
    input  logic [DIV_W-1:0] req_high,
`endif
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             piezo_out
);

    localparam int unsigned c_ms_cyc = ms_cycles(CLK_HZ);

    tone_state_t      state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [DUR_W-1:0] dur_q;
    logic [DUR_W-1:0] gap_q;
    logic [DUR_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [DIV_W:0]   ph_cnt_q, ph_cnt_d;
    logic             piezo_q, piezo_d;
    logic             done_q, done_d;
    logic             busy_q;

    logic             w_accept;
    logic             w_tick;
    logic             w_restart;
    logic             w_audible;
    logic [DUR_W:0]   w_ms_inc;
    logic [DIV_W:0]   w_wave_ph;
    logic             w_wave_piezo;

`ifdef PIEZO_DUTY_EN
    logic [DIV_W-1:0] high_q;
    logic [DIV_W:0]   w_two_n;
    logic [DIV_W:0]   w_high_eff;
    logic [DIV_W:0]   w_ph_next;
`else
    logic [DIV_W:0]   w_half_last;
`endif

    assign w_accept  = req_valid && req_ready;
    assign w_audible = (div_q >= DIV_W'(2));
    assign w_ms_inc  = {1'b0, ms_cnt_q} + (DUR_W + 1)'(1);

    // Millisecond prescaler, restarted on every state entry and held in IDLE.
    ms_tick_gen #(
        .MS_CYC  (c_ms_cyc)
    ) u_ms_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_restart),
        .tick    (w_tick)
    );

`ifdef PIEZO_DUTY_EN
    // Waveform advance: phase runs over a 2N period, high while below the clamped high time.
    always_comb begin
        w_two_n    = {div_q, 1'b0};
        w_high_eff = {1'b0, high_q};
        if (high_q == '0) begin
            w_high_eff = (DIV_W + 1)'(1);
        end else if ({1'b0, high_q} >= w_two_n) begin
            w_high_eff = w_two_n - (DIV_W + 1)'(1);
        end
        w_ph_next = ph_cnt_q + (DIV_W + 1)'(1);
        if (ph_cnt_q == (w_two_n - (DIV_W + 1)'(1))) begin
            w_ph_next = '0;
        end
        w_wave_ph    = w_ph_next;
        w_wave_piezo = (w_ph_next < w_high_eff);
        if (!w_audible) begin
            w_wave_ph    = '0;
            w_wave_piezo = 1'b0;
        end
    end
`else
    // Waveform advance: toggle after N cycles in each half period.
    always_comb begin
        w_half_last  = {1'b0, div_q} - (DIV_W + 1)'(1);
        w_wave_ph    = ph_cnt_q + (DIV_W + 1)'(1);
        w_wave_piezo = piezo_q;
        if (ph_cnt_q == w_half_last) begin
            w_wave_ph    = '0;
            w_wave_piezo = ~piezo_q;
        end
        if (!w_audible) begin
            w_wave_ph    = '0;
            w_wave_piezo = 1'b0;
        end
    end
`endif

    // Next-state logic; counters and pin default to zero so every exit clears them.
    always_comb begin
        state_d  = state_q;
        ms_cnt_d = '0;
        ph_cnt_d = '0;
        piezo_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_dur_ms != '0) begin
                        state_d = TONE;
                        piezo_d = (req_half_div >= DIV_W'(2));
                    end else if (req_gap_ms != '0) begin
                        state_d = GAP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            TONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (w_tick && (w_ms_inc == {1'b0, dur_q})) begin
                    if (gap_q != '0) begin
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    ms_cnt_d = w_tick ? w_ms_inc[DUR_W-1:0] : ms_cnt_q;
                    ph_cnt_d = w_wave_ph;
                    piezo_d  = w_wave_piezo;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (w_tick && (w_ms_inc == {1'b0, gap_q})) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    ms_cnt_d = w_tick ? w_ms_inc[DUR_W-1:0] : ms_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign w_restart = (state_q == IDLE) || (state_d != state_q);

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ms_cnt_q <= '0;
            ph_cnt_q <= '0;
            piezo_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            ph_cnt_q <= ph_cnt_d;
            piezo_q  <= piezo_d;
            done_q   <= done_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // Request fields captured on accept; ignored afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            dur_q  <= '0;
            gap_q  <= '0;
`ifdef PIEZO_DUTY_EN
            high_q <= '0;
`endif
        end else if (w_accept) begin
            div_q  <= req_half_div;
            dur_q  <= req_dur_ms;
            gap_q  <= req_gap_ms;
`ifdef PIEZO_DUTY_EN
            high_q <= req_high;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = busy_q;
    assign done      = done_q;
    assign piezo_out = piezo_q;

endmodule : piezo_tone_seq
`default_nettype wire

// File: tb/tb_piezo_tone_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_piezo_tone_seq
//  Description : Self-checking bench for piezo_tone_seq at CLK_HZ=10_000
//                (10 cycles per ms). A request-level model predicts every
//                output each cycle; literal patterns pin the model itself.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piezo_tone_seq;

    localparam int MS = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [23:0] req_half_div = '0;
    logic [15:0] req_dur_ms = '0;
    logic [15:0] req_gap_ms = '0;
`ifdef PIEZO_DUTY_EN
    logic [23:0] req_high = '0;
`endif
    logic        abort = 1'b0;
    wire         req_ready;
    wire         busy;
    wire         done;
    wire         piezo_out;

    always #5 clk = ~clk;

    piezo_tone_seq #(
        .CLK_HZ       (10_000),
        .DIV_W        (24),
        .DUR_W        (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_half_div (req_half_div),
        .req_dur_ms   (req_dur_ms),
        .req_gap_ms   (req_gap_ms),
`ifdef PIEZO_DUTY_EN
        .req_high     (req_high),
`endif
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .piezo_out    (piezo_out)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit piezo_log [0:4095];
    bit busy_log  [0:4095];
    bit done_log  [0:4095];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // ------------------------------------------------------------------
    // Request-level model: t counts cycles since accept; tone occupies
    // t=1..D, gap t=D+1..D+G, done follows the last busy cycle.
    // ------------------------------------------------------------------
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_t = 0, m_D = 0, m_G = 0, m_N = 0, m_H = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_t      <= 0;
        end else if (!m_active) begin
            m_done <= 1'b0;
            if (req_valid) begin
                m_N <= int'(req_half_div);
                m_D <= int'(req_dur_ms) * MS;
                m_G <= int'(req_gap_ms) * MS;
`ifdef PIEZO_DUTY_EN
                m_H <= int'(req_high);
`else
                m_H <= int'(req_half_div);
`endif
                m_t <= 1;
                if (req_dur_ms == 16'd0 && req_gap_ms == 16'd0) m_done <= 1'b1;
                else m_active <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            if (abort) begin
                m_active <= 1'b0;
            end else if (m_t == m_D + m_G) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    function automatic bit exp_piezo();
        int heff;
        if (!m_active || m_t > m_D || m_N < 2) return 1'b0;
        heff = m_H;
        if (heff < 1) heff = 1;
        if (heff > 2 * m_N - 1) heff = 2 * m_N - 1;
        return ((m_t - 1) % (2 * m_N)) < heff;
    endfunction

    // Per-cycle compare and log, mid-cycle on the falling edge.
    always @(negedge clk) begin
        chk("ready", req_ready, !m_active);
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("piezo", piezo_out, exp_piezo());
        if (cyc + 1 < 4096) begin
            piezo_log[cyc + 1] <= piezo_out;
            busy_log[cyc + 1]  <= busy;
            done_log[cyc + 1]  <= done;
        end
        cyc <= cyc + 1;
    end

    // sel: 0=piezo 1=busy 2=done
    function automatic int cnt_log(input int sel, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            if (i >= 0 && i < 4096) begin
                if (sel == 0 && piezo_log[i]) n++;
                if (sel == 1 && busy_log[i])  n++;
                if (sel == 2 && done_log[i])  n++;
            end
        end
        return n;
    endfunction

    function automatic int first_done(input int a, input int b);
        for (int i = a; i <= b; i++) begin
            if (i >= 0 && i < 4096 && done_log[i]) return i - a + 1;
        end
        return -1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input int d, input int g, input int h, output int acc);
        bit got;
        req_half_div = 24'(n);
        req_dur_ms   = 16'(d);
        req_gap_ms   = 16'(g);
`ifdef PIEZO_DUTY_EN
        req_high     = 24'(h);
`else
        if (h < 0) req_half_div = 24'(n);
`endif
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) got = 1'b1;
        end
        if (!got) fail_now("send_ready");
        @(posedge clk);
        acc = cyc;
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [19:0] v20, pat20;
        logic [9:0]  v10, pat10;

        // Reset state
        wait_cyc(3);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_piezo", piezo_out, 0);
        rst_n = 1'b1;
        wait_cyc(2);

        // 1: reset mid-TONE, then a normal request
        send(3, 5, 0, 3, acc);
        wait_cyc(12);
        chk("t1_pre_piezo", piezo_out, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_piezo", piezo_out, 0);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_done", done, 0);
        chk("t1_rst_ready", req_ready, 1);
        wait_cyc(1);
        rst_n = 1'b1;
        send(2, 1, 0, 2, acc);
        wait_cyc(14);
        chk("t1_new_busy", busy_log[acc + 1], 1);
        chk("t1_new_done", first_done(acc + 1, acc + 14), 11);

        // 2: N=3, dur=2, gap=1
        send(3, 2, 1, 3, acc);
        wait_cyc(40);
        pat20 = 20'b11100011100011100011;
        for (int i = 1; i <= 20; i++) v20[20 - i] = piezo_log[acc + i];
        chk("t2_pattern", v20, pat20);
        chk("t2_silent_after", cnt_log(0, acc + 21, acc + 40), 0);
        chk("t2_busy_len", cnt_log(1, acc + 1, acc + 40), 30);
        chk("t2_done_at", first_done(acc + 1, acc + 40), 31);
        chk("t2_done_cnt", cnt_log(2, acc + 1, acc + 40), 1);

        // 3: zero/zero, then a rest tone
        send(3, 0, 0, 3, acc);
        wait_cyc(3);
        chk("t3_zz_done", done_log[acc + 1], 1);
        chk("t3_zz_busy", busy_log[acc + 1], 0);
        chk("t3_zz_piezo", cnt_log(0, acc + 1, acc + 3), 0);
        send(1, 1, 0, 1, acc);
        wait_cyc(15);
        chk("t3_rest_busy", cnt_log(1, acc + 1, acc + 15), 10);
        chk("t3_rest_piezo", cnt_log(0, acc + 1, acc + 15), 0);
        chk("t3_rest_done", first_done(acc + 1, acc + 15), 11);

        // abort in IDLE is ignored; abort in TONE returns without done
        abort = 1'b1;
        wait_cyc(2);
        abort = 1'b0;
        send(4, 3, 0, 4, acc);
        wait_cyc(5);
        abort = 1'b1;
        wait_cyc(1);
        abort = 1'b0;
        wait_cyc(4);
        chk("abort_tone_done", cnt_log(2, acc + 1, acc + 10), 0);
        chk("abort_tone_busy", cnt_log(1, acc + 1, acc + 10), 6);

        // 4: abort on the gap-expiry cycle, request held during TONE
        send(3, 1, 2, 3, acc);
        req_half_div = 24'd2;
        req_dur_ms   = 16'd1;
        req_gap_ms   = 16'd0;
`ifdef PIEZO_DUTY_EN
        req_high     = 24'd2;
`endif
        req_valid    = 1'b1;
        wait_cyc(29);
        abort = 1'b1;
        wait_cyc(1);
        abort = 1'b0;
        wait_cyc(1);
        req_valid = 1'b0;
        wait_cyc(15);
        chk("t4_no_done", cnt_log(2, acc + 1, acc + 31), 0);
        chk("t4_busy_last", busy_log[acc + 30], 1);
        chk("t4_idle", busy_log[acc + 31], 0);
        chk("t4_held_accept", busy_log[acc + 32], 1);
        chk("t4_held_piezo", piezo_log[acc + 32], 1);
        chk("t4_held_done", done_log[acc + 42], 1);

        // 5: back-to-back, fields changed after accept
        send(2, 1, 0, 2, acc);
        req_half_div = 24'd5;
        req_dur_ms   = 16'd2;
        req_gap_ms   = 16'd0;
`ifdef PIEZO_DUTY_EN
        req_high     = 24'd5;
`endif
        req_valid    = 1'b1;
        wait_cyc(11);
        req_valid = 1'b0;
        wait_cyc(25);
        pat10 = 10'b1100110011;
        for (int i = 1; i <= 10; i++) v10[10 - i] = piezo_log[acc + i];
        chk("t5_first_pattern", v10, pat10);
        chk("t5_done", done_log[acc + 11], 1);
        chk("t5_gap_cycle", busy_log[acc + 11], 0);
        chk("t5_second_busy", busy_log[acc + 12], 1);
        chk("t5_second_done", done_log[acc + 32], 1);

`ifdef PIEZO_DUTY_EN
        // 6: duty control with clamping
        begin
            logic [7:0] v8, p8;
            int hs [3] = '{2, 0, 9};
            logic [7:0] ps [3] = '{8'b11000000, 8'b10000000, 8'b11111110};
            for (int k = 0; k < 3; k++) begin
                send(4, 1, 0, hs[k], acc);
                wait_cyc(12);
                p8 = ps[k];
                for (int i = 1; i <= 8; i++) v8[8 - i] = piezo_log[acc + i];
                chk("t6_duty_pattern", v8, p8);
            end
        end
`endif

        wait_cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_piezo_tone_seq
`default_nettype wire
